xeng_corr_rd_sched: RTL

- Scheduler for the component-tracker correction readout: sequences antenna-pair read requests into the dual-port correction vector accumulators, one sweep per full baseline triangle.
- Manages the ping-pong buffer select and the end-of-triangle flag.
- Emits a read-latency-aligned valid/flag stream for the downstream correction adders.
- Sits between the X-engine sync/valid timing and the correction vacc read ports.

---
 rtl/xeng_corr_rd_sched.sv | 125 ++++++++++++
 1 files changed

// File: rtl/xeng_corr_rd_sched.sv
// Correction-vacc read scheduler: walks every antenna pair once per sweep and emits a latency-aligned valid/flag stream.
// Optional macro XENG_CORR_RD_SCHED_SYNC_CHECK_EN adds a sticky sync_err output for syncs that land off a sweep boundary.
module xeng_corr_rd_sched #(
    parameter int N_ANTS              = 32,
    parameter int SERIAL_ACC_LEN_BITS = 7,
    parameter int READ_LATENCY        = 2,
    localparam int ANT_BITS = (N_ANTS > 1) ? $clog2(N_ANTS) : 1,
    localparam int N_TAPS   = N_ANTS / 2 + 1,
    localparam int TAP_BITS = (N_TAPS > 2) ? $clog2(N_TAPS) : 1
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                sync,
    input  logic                en,
    output logic [ANT_BITS-1:0] ant_a_sel,
    output logic [ANT_BITS-1:0] ant_b_sel,
    output logic [TAP_BITS-1:0] tap_idx,
    output logic                req_vld,
    output logic                buf_sel,
    output logic                last_triangle,
    output logic                rd_vld,
    output logic                rd_buf_sel,
    output logic                rd_last_triangle,
    output logic                sweep_done
`ifdef XENG_CORR_RD_SCHED_SYNC_CHECK_EN
    ,
    output logic                sync_err
`endif
);

    localparam int ACC_LEN = 1 << SERIAL_ACC_LEN_BITS;
    localparam logic [SERIAL_ACC_LEN_BITS:0] TAPS_LIM = (SERIAL_ACC_LEN_BITS + 1)'(N_TAPS);

    if (N_TAPS > ACC_LEN || N_ANTS < 2 || (1 << ANT_BITS) != N_ANTS || READ_LATENCY < 1) begin : g_bad_cfg
        $error("xeng_corr_rd_sched: illegal parameter combination");
    end

    typedef enum logic {ST_IDLE, ST_RUN} state_t;

    state_t                         state_reg;
    logic [SERIAL_ACC_LEN_BITS-1:0] win_ctr_reg;
    logic [ANT_BITS-1:0]            ant_ctr_reg;
    logic                           wrap_pend_reg;
    logic [2:0]                     dly_reg [READ_LATENCY];

    logic adv;
    logic sweep_wrap;
    logic req_next;

    assign adv        = (state_reg == ST_RUN) && en;
    assign sweep_wrap = adv && (&win_ctr_reg) && (&ant_ctr_reg);
    assign req_next   = adv && ({1'b0, win_ctr_reg} < TAPS_LIM);

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_reg     <= ST_IDLE;
            win_ctr_reg   <= '0;
            ant_ctr_reg   <= '0;
            wrap_pend_reg <= 1'b0;
            ant_a_sel     <= '0;
            ant_b_sel     <= '0;
            tap_idx       <= '0;
            req_vld       <= 1'b0;
            buf_sel       <= 1'b0;
            last_triangle <= 1'b0;
            sweep_done    <= 1'b0;
        end else begin
            req_vld       <= req_next;
            last_triangle <= req_next && (&ant_ctr_reg);
            if (req_next) begin
                ant_a_sel <= ant_ctr_reg;
                ant_b_sel <= ant_ctr_reg - ANT_BITS'(win_ctr_reg);
                tap_idx   <= TAP_BITS'(win_ctr_reg);
            end
            // The buffer flips one edge after the final enabled cycle; a coincident sync cancels it.
            buf_sel       <= buf_sel ^ wrap_pend_reg;
            sweep_done    <= wrap_pend_reg;
            wrap_pend_reg <= sweep_wrap && !sync;

            if (sync) begin
                state_reg   <= ST_RUN;
                win_ctr_reg <= '0;
                ant_ctr_reg <= '0;
            end else if (adv) begin
                win_ctr_reg <= win_ctr_reg + SERIAL_ACC_LEN_BITS'(1);
                if (&win_ctr_reg) begin
                    ant_ctr_reg <= ant_ctr_reg + ANT_BITS'(1);
                end
            end
        end
    end

    // Delay line shifts every cycle, even with en low, so in-flight reads keep draining.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            for (int i = 0; i < READ_LATENCY; i++) begin
                dly_reg[i] <= '0;
            end
        end else begin
            dly_reg[0] <= {req_vld, buf_sel, last_triangle};
            for (int i = 1; i < READ_LATENCY; i++) begin
                dly_reg[i] <= dly_reg[i-1];
            end
        end
    end

    assign {rd_vld, rd_buf_sel, rd_last_triangle} = dly_reg[READ_LATENCY-1];

`ifdef XENG_CORR_RD_SCHED_SYNC_CHECK_EN
    logic sync_aligned;

    // A sync on the last cycle of a sweep starts the next sweep exactly on time, so it is aligned too.
    assign sync_aligned = ((win_ctr_reg == '0) && (ant_ctr_reg == '0)) ||
                          ((&win_ctr_reg) && (&ant_ctr_reg));

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            sync_err <= 1'b0;
        end else if (sync && (state_reg == ST_RUN) && !sync_aligned) begin
            sync_err <= 1'b1;
        end
    end
`endif

endmodule
